// File: rtl/rf_write_scheduler.sv
// Register-file write-port arbiter (A over B) with commit register and per-register busy scoreboard.
// Optional B anti-starvation counter is enabled by defining RFSCHED_STARVE_EN.
module rf_write_scheduler #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        a_valid,
    input  logic [4:0]  a_wsel,
    input  logic [31:0] a_wdat,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_wsel,
    input  logic [31:0] b_wdat,
    output logic        b_ready,
    output logic        rf_wen,
    output logic [4:0]  rf_wsel,
    output logic [31:0] rf_wdat,
    input  logic        rsv_valid,
    input  logic [4:0]  rsv_sel,
    output logic        rsv_ready,
    input  logic [4:0]  rsel1,
    input  logic [4:0]  rsel2,
    output logic        busy1,
    output logic        busy2
);

    if (STARVE_LIMIT < 1) begin : g_limit_check
        $error("rf_write_scheduler: STARVE_LIMIT must be >= 1");
    end

    logic        a_grant, b_grant, b_prio;
    logic        wen_q, wen_d;
    logic [4:0]  wsel_q, wsel_d;
    logic [31:0] wdat_q, wdat_d;
    logic [31:0] busy_q, busy_d;
    logic [4:0]  commit_sel;
    logic        rsv_accept;

`ifdef RFSCHED_STARVE_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] starve_q, starve_d;

    assign b_prio = b_valid && (starve_q == CW'(STARVE_LIMIT));

    // Counts consecutive cycles B is held off; saturates so B keeps priority until served.
    always_comb begin
        starve_d = starve_q;
        if (!b_valid || b_grant) begin
            starve_d = '0;
        end else if (starve_q != CW'(STARVE_LIMIT)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign b_prio = 1'b0;
`endif

    assign a_grant = a_valid && !b_prio;
    assign b_grant = b_valid && !a_grant;
    assign a_ready = a_grant;
    assign b_ready = b_grant;

    assign commit_sel = a_grant ? a_wsel : b_wsel;
    assign rsv_ready  = !rsv_valid || (rsv_sel == 5'd0) || !busy_q[rsv_sel];
    assign rsv_accept = rsv_valid && rsv_ready && (rsv_sel != 5'd0);
    assign busy1      = busy_q[rsel1];
    assign busy2      = busy_q[rsel2];

    always_comb begin
        wen_d  = 1'b0;
        wsel_d = wsel_q;
        wdat_d = wdat_q;
        if (a_grant) begin
            wen_d  = (a_wsel != 5'd0);
            wsel_d = a_wsel;
            wdat_d = a_wdat;
        end else if (b_grant) begin
            wen_d  = (b_wsel != 5'd0);
            wsel_d = b_wsel;
            wdat_d = b_wdat;
        end
    end

    // Commit clears first, then a new reservation sets; refusal of a busy register keeps these disjoint.
    always_comb begin
        busy_d = busy_q;
        if (a_grant || b_grant) begin
            busy_d[commit_sel] = 1'b0;
        end
        if (rsv_accept) begin
            busy_d[rsv_sel] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wen_q  <= 1'b0;
            wsel_q <= '0;
            wdat_q <= '0;
            busy_q <= '0;
        end else begin
            wen_q  <= wen_d;
            wsel_q <= wsel_d;
            wdat_q <= wdat_d;
            busy_q <= busy_d;
        end
    end

    assign rf_wen  = wen_q;
    assign rf_wsel = wsel_q;
    assign rf_wdat = wdat_q;

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Self-checking bench for rf_write_scheduler: vector table, directed corner sequences, randomized run vs reference model.
module tb_rf_write_scheduler;
    localparam int LIMIT = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        a_valid, b_valid, rsv_valid;
    logic [4:0]  a_wsel, b_wsel, rsv_sel, rsel1, rsel2;
    logic [31:0] a_wdat, b_wdat;
    logic        a_ready, b_ready, rsv_ready, busy1, busy2, rf_wen;
    logic [4:0]  rf_wsel;
    logic [31:0] rf_wdat;

    always #5 CLK = ~CLK;

    rf_write_scheduler #(.STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .RST(RST),
        .a_valid(a_valid), .a_wsel(a_wsel), .a_wdat(a_wdat), .a_ready(a_ready),
        .b_valid(b_valid), .b_wsel(b_wsel), .b_wdat(b_wdat), .b_ready(b_ready),
        .rf_wen(rf_wen), .rf_wsel(rf_wsel), .rf_wdat(rf_wdat),
        .rsv_valid(rsv_valid), .rsv_sel(rsv_sel), .rsv_ready(rsv_ready),
        .rsel1(rsel1), .rsel2(rsel2), .busy1(busy1), .busy2(busy2)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state: set of reserved registers, B wait streak, and the expected write-port contents.
    bit [31:0] m_busy;
    int        m_wait;
    bit        m_wen;
    bit [4:0]  m_wsel;
    bit [31:0] m_wdat;

    typedef struct {
        logic        av; logic [4:0] as; logic [31:0] ad;
        logic        bv; logic [4:0] bs; logic [31:0] bd;
        logic        rv; logic [4:0] rs; logic [4:0] r1; logic [4:0] r2;
        logic        e_ar, e_br, e_rr, e_b1, e_b2, e_wen;
        logic [4:0]  e_wsel; logic [31:0] e_wdat;
    } vec_t;

    vec_t vec[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_bforce();
`ifdef RFSCHED_STARVE_EN
        return b_valid && (m_wait >= LIMIT);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_aready();
        return a_valid && !m_bforce();
    endfunction

    function automatic bit m_bready();
        return b_valid && !m_aready();
    endfunction

    function automatic bit m_rready();
        return !rsv_valid || rsv_sel == 5'd0 || !m_busy[rsv_sel];
    endfunction

    function automatic bit exp_b_win(input int i);
`ifdef RFSCHED_STARVE_EN
        return (i % (LIMIT + 1)) == LIMIT;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_check(input string tag);
        chk({tag, ".a_ready"}, a_ready, m_aready());
        chk({tag, ".b_ready"}, b_ready, m_bready());
        chk({tag, ".rsv_ready"}, rsv_ready, m_rready());
        chk({tag, ".busy1"}, busy1, (rsel1 != 0) && m_busy[rsel1]);
        chk({tag, ".busy2"}, busy2, (rsel2 != 0) && m_busy[rsel2]);
        chk({tag, ".rf_wen"}, rf_wen, m_wen);
        if (m_wen) begin
            chk({tag, ".rf_wsel"}, rf_wsel, m_wsel);
            chk({tag, ".rf_wdat"}, rf_wdat, m_wdat);
        end
    endtask

    // Advance the reference by one rising edge using the inputs currently applied, then clock the DUT.
    task automatic step();
        bit acc_a, acc_b, acc_r;
        bit [4:0] sel;
        if (RST) begin
            m_busy = '0; m_wait = 0; m_wen = 0; m_wsel = '0; m_wdat = '0;
        end else begin
            acc_a = m_aready();
            acc_b = m_bready();
            acc_r = rsv_valid && m_rready();
            m_wen = 1'b0;
            if (acc_a || acc_b) begin
                sel    = acc_a ? a_wsel : b_wsel;
                m_wen  = (sel != 0);
                m_wsel = sel;
                m_wdat = acc_a ? a_wdat : b_wdat;
                m_busy[sel] = 1'b0;
            end
            if (acc_r && rsv_sel != 0) m_busy[rsv_sel] = 1'b1;
            if (b_valid && !acc_b) m_wait = (m_wait < LIMIT) ? m_wait + 1 : LIMIT;
            else m_wait = 0;
        end
        m_busy[0] = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        a_valid = 0; a_wsel = '0; a_wdat = '0;
        b_valid = 0; b_wsel = '0; b_wdat = '0;
        rsv_valid = 0; rsv_sel = '0; rsel1 = '0; rsel2 = '0;
    endtask

    initial begin
        bit hold_a, hold_b;
        // {av,as,ad, bv,bs,bd, rv,rs,r1,r2, e_ar,e_br,e_rr,e_b1,e_b2,e_wen,e_wsel,e_wdat}
        vec[0]  = '{1, 5,  32'hDEADBEEF, 0, 0,  32'h0,  0, 0, 0,  0,  1, 0, 1, 0, 0, 0, 0,  32'h0};
        vec[1]  = '{0, 0,  32'h0,        0, 0,  32'h0,  0, 0, 0,  0,  0, 0, 1, 0, 0, 1, 5,  32'hDEADBEEF};
        vec[2]  = '{0, 0,  32'h0,        0, 0,  32'h0,  0, 0, 0,  0,  0, 0, 1, 0, 0, 0, 0,  32'h0};
        vec[3]  = '{0, 0,  32'h0,        0, 0,  32'h0,  1, 7, 7,  0,  0, 0, 1, 0, 0, 0, 0,  32'h0};
        vec[4]  = '{0, 0,  32'h0,        0, 0,  32'h0,  1, 7, 7,  0,  0, 0, 0, 1, 0, 0, 0,  32'h0};
        vec[5]  = '{0, 0,  32'h0,        1, 7,  32'h77, 1, 7, 7,  0,  0, 1, 0, 1, 0, 0, 0,  32'h0};
        vec[6]  = '{0, 0,  32'h0,        0, 0,  32'h0,  1, 7, 7,  0,  0, 0, 1, 0, 0, 1, 7,  32'h77};
        vec[7]  = '{0, 0,  32'h0,        0, 0,  32'h0,  0, 0, 7,  7,  0, 0, 1, 1, 1, 0, 0,  32'h0};
        vec[8]  = '{1, 0,  32'h1234,     0, 0,  32'h0,  1, 0, 7,  0,  1, 0, 1, 1, 0, 0, 0,  32'h0};
        vec[9]  = '{0, 0,  32'h0,        0, 0,  32'h0,  1, 0, 0,  0,  0, 0, 1, 0, 0, 0, 0,  32'h0};
        vec[10] = '{1, 12, 32'hCAFEF00D, 1, 13, 32'h11, 0, 0, 0,  0,  1, 0, 1, 0, 0, 0, 0,  32'h0};
        vec[11] = '{0, 0,  32'h0,        1, 13, 32'h11, 0, 0, 13, 0,  0, 1, 1, 0, 0, 1, 12, 32'hCAFEF00D};
        vec[12] = '{0, 0,  32'h0,        0, 0,  32'h0,  0, 0, 7,  0,  0, 0, 1, 1, 0, 1, 13, 32'h11};

        idle();
        RST = 1'b1;
        #1;
        step();
        RST = 1'b0;
        #1;
        chk("reset.rf_wen", rf_wen, 1'b0);
        chk("reset.rf_wsel", rf_wsel, 5'd0);
        chk("reset.rf_wdat", rf_wdat, 32'h0);
        for (int r = 0; r < 32; r++) begin
            rsel1 = 5'(r);
            #1;
            chk($sformatf("reset.busy[%0d]", r), busy1, 1'b0);
        end
        rsel1 = '0;

        for (int i = 0; i < 13; i++) begin
            a_valid = vec[i].av; a_wsel = vec[i].as; a_wdat = vec[i].ad;
            b_valid = vec[i].bv; b_wsel = vec[i].bs; b_wdat = vec[i].bd;
            rsv_valid = vec[i].rv; rsv_sel = vec[i].rs; rsel1 = vec[i].r1; rsel2 = vec[i].r2;
            #1;
            chk($sformatf("vec%0d.a_ready", i), a_ready, vec[i].e_ar);
            chk($sformatf("vec%0d.b_ready", i), b_ready, vec[i].e_br);
            chk($sformatf("vec%0d.rsv_ready", i), rsv_ready, vec[i].e_rr);
            chk($sformatf("vec%0d.busy1", i), busy1, vec[i].e_b1);
            chk($sformatf("vec%0d.busy2", i), busy2, vec[i].e_b2);
            chk($sformatf("vec%0d.rf_wen", i), rf_wen, vec[i].e_wen);
            if (vec[i].e_wen) begin
                chk($sformatf("vec%0d.rf_wsel", i), rf_wsel, vec[i].e_wsel);
                chk($sformatf("vec%0d.rf_wdat", i), rf_wdat, vec[i].e_wdat);
            end
            step();
        end

        // Both sources held: A wins unless B has waited LIMIT cycles.
        idle();
        a_valid = 1; a_wsel = 5'd3; a_wdat = 32'hA5A5A5A5;
        b_valid = 1; b_wsel = 5'd4; b_wdat = 32'hB4B4B4B4;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("prio%0d.b_ready", i), b_ready, exp_b_win(i));
            chk($sformatf("prio%0d.a_ready", i), a_ready, !exp_b_win(i));
            if (i > 0) begin
                chk($sformatf("prio%0d.rf_wen", i), rf_wen, 1'b1);
                chk($sformatf("prio%0d.rf_wsel", i), rf_wsel, exp_b_win(i - 1) ? 5'd4 : 5'd3);
            end
            model_check($sformatf("prio%0d", i));
            step();
        end
        idle();
        #1;
        chk("prio_last.rf_wsel", rf_wsel, exp_b_win(9) ? 5'd4 : 5'd3);
        step();

        // Reset mid-operation with a reservation, an in-flight write and a B wait streak.
        a_valid = 1; a_wsel = 5'd2; a_wdat = 32'h22;
        b_valid = 1; b_wsel = 5'd6; b_wdat = 32'h66;
        rsv_valid = 1; rsv_sel = 5'd9; rsel1 = 5'd9;
        #1;
        model_check("rstmid.pre");
        step();
        rsv_valid = 0;
        RST = 1'b1;
        #1;
        chk("rstmid.inflight_wen", rf_wen, 1'b1);
        chk("rstmid.busy9_before", busy1, 1'b1);
        step();
        RST = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (i == 0) begin
                chk("rstmid.rf_wen", rf_wen, 1'b0);
                chk("rstmid.busy9", busy1, 1'b0);
            end
            chk($sformatf("rstmid%0d.b_ready", i), b_ready, exp_b_win(i));
            model_check($sformatf("rstmid%0d", i));
            step();
        end

        // Randomized traffic with held requests, reservations and occasional reset.
        idle();
        hold_a = 0;
        hold_b = 0;
        for (int i = 0; i < 800; i++) begin
            if (!hold_a) begin
                a_valid = ($urandom_range(0, 2) != 0);
                a_wsel = 5'($urandom_range(0, 31));
                a_wdat = $urandom;
            end
            if (!hold_b) begin
                b_valid = ($urandom_range(0, 1) != 0);
                b_wsel = 5'($urandom_range(0, 31));
                b_wdat = $urandom;
            end
            rsv_valid = ($urandom_range(0, 1) != 0);
            rsv_sel = 5'($urandom_range(0, 31));
            rsel1 = 5'($urandom_range(0, 31));
            rsel2 = 5'($urandom_range(0, 31));
            RST = ($urandom_range(0, 99) == 0);
            #1;
            model_check($sformatf("rnd%0d", i));
            hold_a = a_valid && !m_aready() && !RST;
            hold_b = b_valid && !m_bready() && !RST;
            step();
        end
        RST = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
